lb_axil_indirect: RTL
=====================

# lb_axil_indirect

Parametrised N-channel indirect AXI4-Lite access engine on the local bus clock. Each channel presents an address, a write/read select, write data and a start strobe from the cfg register space. Requests are snapshotted, arbitrated round-robin onto one AXI4-Lite master port, and each channel gets back read data, a read-valid pulse, busy and a sticky error flag. It replaces per-device hand-wired indirect AXI ports with one generic block that adds queuing, fairness, response checking and timeout.

## Interface
Parameters:
- NCH, 6, number of request channels (1..16)
- AWIDTH, 32, AXI address width
- DWIDTH, 32, AXI data width (32 or 64)
- TIMEOUT, 255, maximum cycles per transaction in a non-IDLE state (≥4)

Ports (clock and reset first):
- lbclk  in  1  single clock for all logic
- rst  in  1  reset, asynchronous, active-high
- ch_addr  in  NCH*AWIDTH  per-channel address, channel i at [i*AWIDTH +: AWIDTH]
- ch_w0r1  in  NCH  0 = write, 1 = read
- ch_wdata  in  NCH*DWIDTH  per-channel write data
- stb_ch_start  in  NCH  one-cycle start strobe per channel
- ch_rdata  out  NCH*DWIDTH  last read data per channel
- ch_rdatavalid  out  NCH  one-cycle pulse when ch_rdata updates (reads only)
- ch_busy  out  NCH  request pending or in flight
- ch_err  out  NCH  sticky: SLVERR/DECERR, timeout or overrun
- m_awaddr/awvalid/awready, m_wdata/wstrb/wvalid/wready, m_bresp/bvalid/bready, m_araddr/arvalid/arready, m_rdata/rresp/rvalid/rready: standard AXI4-Lite master signals, widths per AWIDTH/DWIDTH; wstrb all ones.

## Operation
- Capture: stb_ch_start[i] while !ch_busy[i] snapshots addr/w0r1/wdata into channel-i registers, sets busy, clears ch_err[i].
- Overrun: strobe while ch_busy[i] is ignored (snapshot unchanged), sets ch_err[i].
- Arbitration: in IDLE, grant the lowest pending index strictly after the last granted index, wrapping; after reset the last granted index is NCH-1, so channel 0 wins first.
- FSM states: IDLE, WADDR, WRESP, RADDR, RDATA.
- IDLE -> WADDR (write) or RADDR (read) on grant; m_awvalid and m_wvalid assert together in WADDR, each drops independently on its handshake.
- WADDR -> WRESP once both handshakes are done (same cycle or different cycles). WRESP holds m_bready=1; on m_bvalid go to IDLE.
- RADDR holds m_arvalid until m_arready, then RDATA with m_rready=1. On m_rvalid, latch m_rdata into ch_rdata[i] and go to IDLE.
- Completion clears ch_busy[i]. Response != OKAY sets ch_err[i]; read data is still latched and pulsed.
- Timeout: cycle counter reset on grant. If it reaches TIMEOUT before completion: drop all valid/ready, go to IDLE, clear busy, set err. For reads, ch_rdata[i] = 0xDEADBEEF (zero-extended) with a rdatavalid pulse.
- A completing channel strobed in its completion cycle: the new request is captured (busy stays 1) and ch_err[i] is cleared. Capture wins over the completion's error set.

## Timing
- Reset: all AXI valid/ready 0, ch_rdata 0, ch_rdatavalid 0, ch_busy 0, ch_err 0, FSM IDLE, all pending cleared.
- Strobe at cycle 0 -> ch_busy=1 at cycle 1. If the FSM is IDLE, grant at cycle 1 and m_arvalid/m_awvalid at cycle 2.
- Read with zero-wait slave: AR handshake cycle 2, rvalid cycle 3, ch_rdatavalid pulse and busy=0 at cycle 4.
- Back-to-back grants: one IDLE cycle between transactions.
- All outputs are registered; no combinational path from AXI inputs to AXI outputs.

## Structure
- Package lb_axil_pkg: FSM state enum, AXI resp constants (OKAY=2'b00), TIMEOUT_RDATA constant 0xDEADBEEF.
- Sub-module lb_rr_arbiter (parameter N): pending vector plus last-grant pointer in, one-hot grant plus index out, combinational.
- Top: per-channel snapshot registers, FSM, timeout counter, output registers.

## Test plan
- Single read, ch0 addr 0x100, slave returns 0x12345678 OKAY, zero wait -> ch_rdatavalid[0] at cycle 4, ch_rdata[0]=0x12345678, err=0.
- Write ch2, awready 3 cycles after wready -> WRESP entered only after both handshakes; bvalid OKAY -> busy[2] clears, no rdatavalid.
- Strobe all 6 channels in the same cycle -> grants in order 0,1,2,3,4,5. Re-strobe ch1 and ch4 during ch5 -> next grants 1 then 4.
- Read returns rresp=SLVERR with 0xA5A5A5A5 -> ch_rdata=0xA5A5A5A5, rdatavalid pulses, err=1. Next strobe clears err.
- Slave never asserts arready, TIMEOUT=16 -> arvalid drops 16 cycles after grant, ch_rdata=0xDEADBEEF, err=1, FSM IDLE.
- Strobe a busy channel -> snapshot unchanged, err=1. Assert rst mid-RDATA -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/lb_axil_pkg.sv
// Shared types and constants for the indirect AXI4-Lite access engine.
package lb_axil_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWaddr,
        StWresp,
        StRaddr,
        StRdata
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Read data returned to a channel whose read timed out.
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/lb_rr_arbiter.sv
// Round-robin arbiter: grants the lowest pending index strictly after the last grant, wrapping.
module lb_rr_arbiter #(
    parameter int unsigned N = 6,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  pend,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Scan N slots starting one past the last grant; first pending slot wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int k = 1; k <= int'(N); k++) begin
            int j;
            j = int'(last) + k;
            if (j >= int'(N)) j = j - int'(N);
            if (!valid && pend[j]) begin
                valid  = 1'b1;
                gnt[j] = 1'b1;
                idx    = j[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/lb_axil_indirect.sv
// N-channel indirect AXI4-Lite master: snapshots per-channel requests, arbitrates them
// round-robin onto one AXI4-Lite port and returns read data, busy and sticky error per channel.
module lb_axil_indirect
    import lb_axil_pkg::*;
#(
    parameter int unsigned NCH     = 6,
    parameter int unsigned AWIDTH  = 32,
    parameter int unsigned DWIDTH  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                    lbclk,
    input  logic                    rst,
    input  logic [NCH*AWIDTH-1:0]   ch_addr,
    input  logic [NCH-1:0]          ch_w0r1,
    input  logic [NCH*DWIDTH-1:0]   ch_wdata,
    input  logic [NCH-1:0]          stb_ch_start,
    output logic [NCH*DWIDTH-1:0]   ch_rdata,
    output logic [NCH-1:0]          ch_rdatavalid,
    output logic [NCH-1:0]          ch_busy,
    output logic [NCH-1:0]          ch_err,
    output logic [AWIDTH-1:0]       m_awaddr,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [DWIDTH-1:0]       m_wdata,
    output logic [DWIDTH/8-1:0]     m_wstrb,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    input  logic [1:0]              m_bresp,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    output logic [AWIDTH-1:0]       m_araddr,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    input  logic [DWIDTH-1:0]       m_rdata,
    input  logic [1:0]              m_rresp,
    input  logic                    m_rvalid,
    output logic                    m_rready
);

    localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    // Per-channel snapshot and status
    logic [AWIDTH-1:0]      addr_q  [NCH];
    logic [DWIDTH-1:0]      wdata_q [NCH];
    logic [NCH-1:0]         w0r1_q;
    logic [NCH-1:0]         pend_q, busy_q, err_q, rdv_q;
    logic [NCH*DWIDTH-1:0]  rdata_q;

    // Engine state
    state_e                 state_q, state_d;
    logic [IW-1:0]          cur_q, last_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic                   arvalid_q, arvalid_d, rready_q, rready_d;
    logic [AWIDTH-1:0]      awaddr_q, araddr_q;
    logic [DWIDTH-1:0]      mwdata_q;

    logic [NCH-1:0]         arb_gnt;
    logic [IW-1:0]          arb_idx;
    logic                   arb_valid;

    logic                   take, fin, fin_err, rd_fin;
    logic [DWIDTH-1:0]      rd_val;
    logic [NCH-1:0]         done_vec, cap_vec;

    lb_rr_arbiter #(
        .N (NCH)
    ) u_arb (
        .pend  (pend_q),
        .last  (last_q),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    // Next-state and AXI handshake control; timeout overrides an unfinished transaction.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        take      = 1'b0;
        fin       = 1'b0;
        fin_err   = 1'b0;
        rd_fin    = 1'b0;
        rd_val    = '0;
        if (state_q != StIdle) cnt_d = cnt_q + 1'b1;
        unique case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    take  = 1'b1;
                    // Counter holds cycles elapsed since the grant.
                    cnt_d = CW'(1);
                    if (w0r1_q[arb_idx]) begin
                        state_d   = StRaddr;
                        arvalid_d = 1'b1;
                    end else begin
                        state_d   = StWaddr;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end
                end
            end
            StWaddr: begin
                if (m_awready) awvalid_d = 1'b0;
                if (m_wready)  wvalid_d  = 1'b0;
                if ((!awvalid_q || m_awready) && (!wvalid_q || m_wready)) begin
                    state_d  = StWresp;
                    bready_d = 1'b1;
                end
            end
            StWresp: begin
                if (m_bvalid) begin
                    state_d  = StIdle;
                    bready_d = 1'b0;
                    fin      = 1'b1;
                    fin_err  = (m_bresp != RESP_OKAY);
                end
            end
            StRaddr: begin
                if (m_arready) begin
                    state_d   = StRdata;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            StRdata: begin
                if (m_rvalid) begin
                    state_d  = StIdle;
                    rready_d = 1'b0;
                    fin      = 1'b1;
                    fin_err  = (m_rresp != RESP_OKAY);
                    rd_fin   = 1'b1;
                    rd_val   = m_rdata;
                end
            end
            default: state_d = StIdle;
        endcase
        if (state_q != StIdle && !fin && cnt_q == CW'(TIMEOUT - 1)) begin
            state_d   = StIdle;
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
            fin       = 1'b1;
            fin_err   = 1'b1;
            if (state_q == StRaddr || state_q == StRdata) begin
                rd_fin = 1'b1;
                rd_val = DWIDTH'(TIMEOUT_RDATA);
            end
        end
    end

    // Completion and capture decode per channel; a completing channel may re-capture.
    always_comb begin
        done_vec = '0;
        if (fin) done_vec[cur_q] = 1'b1;
        cap_vec = stb_ch_start & (~busy_q | done_vec);
    end

    // Engine state, AXI output registers and the granted request's address/data.
    always_ff @(posedge lbclk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            cur_q     <= '0;
            last_q    <= IW'(NCH - 1);
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            mwdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            if (take) begin
                cur_q    <= arb_idx;
                last_q   <= arb_idx;
                awaddr_q <= addr_q[arb_idx];
                araddr_q <= addr_q[arb_idx];
                mwdata_q <= wdata_q[arb_idx];
            end
        end
    end

    // Per-channel snapshot, pending/busy/error bookkeeping and read-data return.
    always_ff @(posedge lbclk or posedge rst) begin
        if (rst) begin
            addr_q  <= '{default: '0};
            wdata_q <= '{default: '0};
            w0r1_q  <= '0;
            pend_q  <= '0;
            busy_q  <= '0;
            err_q   <= '0;
            rdv_q   <= '0;
            rdata_q <= '0;
        end else begin
            for (int i = 0; i < int'(NCH); i++) begin
                if (cap_vec[i]) begin
                    addr_q[i]  <= ch_addr[i*AWIDTH +: AWIDTH];
                    wdata_q[i] <= ch_wdata[i*DWIDTH +: DWIDTH];
                    w0r1_q[i]  <= ch_w0r1[i];
                    pend_q[i]  <= 1'b1;
                    busy_q[i]  <= 1'b1;
                    err_q[i]   <= 1'b0;
                end else begin
                    if (stb_ch_start[i]) err_q[i] <= 1'b1;
                    if (done_vec[i]) begin
                        busy_q[i] <= 1'b0;
                        if (fin_err) err_q[i] <= 1'b1;
                    end
                    if (take && arb_gnt[i]) pend_q[i] <= 1'b0;
                end
                rdv_q[i] <= rd_fin && done_vec[i];
                if (rd_fin && done_vec[i]) rdata_q[i*DWIDTH +: DWIDTH] <= rd_val;
            end
        end
    end

    assign ch_rdata      = rdata_q;
    assign ch_rdatavalid = rdv_q;
    assign ch_busy       = busy_q;
    assign ch_err        = err_q;
    assign m_awaddr      = awaddr_q;
    assign m_awvalid     = awvalid_q;
    assign m_wdata       = mwdata_q;
    assign m_wstrb       = '1;
    assign m_wvalid      = wvalid_q;
    assign m_bready      = bready_q;
    assign m_araddr      = araddr_q;
    assign m_arvalid     = arvalid_q;
    assign m_rready      = rready_q;

endmodule
